irq_request_latch: RTL

Front-end request capture stage for the 8:3 priority encoder. It synchronises eight asynchronous request lines, detects rising edges, and latches each event in a sticky pending register. The masked pending vector drives the encoder's `i[7:0]` input and the encoder enable. A four-phase request/acknowledge handshake with the servicing logic clears the serviced bit.

---
 rtl/irq_request_latch_if.sv | 23 ++
 rtl/irq_request_latch.sv | 100 ++++++++++
 2 files changed

// File: rtl/irq_request_latch_if.sv
// Signal bundle between the request latch and its servicing logic / encoder.
// The servicing side is the master; the latch itself uses the slave modport.
interface irq_request_latch_if;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_in;
  logic       ack;
  logic [2:0] ack_id;
  logic [7:0] i;
  logic       en;
  logic       irq;
  logic       busy;

  modport master (
    output irq_in, mask_wr, mask_in, ack, ack_id,
    input  i, en, irq, busy
  );

  modport slave (
    input  irq_in, mask_wr, mask_in, ack, ack_id,
    output i, en, irq, busy
  );
endinterface

// File: rtl/irq_request_latch.sv
// Request capture front end for the 8:3 priority encoder: synchronise, edge-detect,
// latch sticky pending bits and run the four-phase req/ack handshake.
module irq_request_latch #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  irq_request_latch_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  s_d_q;
  logic [7:0]                  pending_q, pending_d;
  logic [7:0]                  ien_q, ien_d;
  state_t                      state_q, state_d;

  logic [7:0] sync_out;
  logic [7:0] rise;
  logic [7:0] clr_vec;
  logic [7:0] masked;
  logic       accept;

  // Stage 0 takes the raw lines; the top stage is the synchronised level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~s_d_q;
  assign masked   = pending_q & ien_q;
  assign accept   = (state_q == ST_REQ) && bus.ack;
  assign clr_vec  = accept ? (8'h01 << bus.ack_id) : 8'h00;

  // Set is OR-ed in after the clear so a coinciding rise wins.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | rise;
    ien_d     = bus.mask_wr ? bus.mask_in : ien_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      ien_q     <= 8'hFF;
    end else begin
      pending_q <= pending_d;
      ien_q     <= ien_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (masked != 8'h00) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.ack) begin
          state_d = ST_SERV;
        end else if (masked == 8'h00) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERV: begin
        if (!bus.ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registers so the encoder sees no glitches.
  assign bus.i    = masked;
  assign bus.en   = (state_q == ST_REQ);
  assign bus.irq  = (state_q == ST_REQ);
  assign bus.busy = (state_q == ST_SERV);

endmodule
